jtframe_pocket_vrx: RTL and testbench

- Receiving end of the Analogue Pocket video bus (24-bit rgb, rgb_clk, de, skip, one-pixel hs/vs pulses).
- Recovers a conventional pixel stream:
  - pixel-enable strobe
  - level hs/vs of programmable width
  - x/y position
  - measured active width/height per frame
- Used in simulation harnesses and frame-capture/debug paths to check and dump what the core sends to the Pocket scaler.
- All inputs are in the same clk domain as the transmitter; no CDC.

---
 rtl/jtframe_pocket_pkg.sv | 12 +
 rtl/jtframe_pocket_vrx_in.sv | 41 ++++
 rtl/jtframe_pocket_vrx.sv | 173 +++++++++++++++++
 tb/tb_jtframe_pocket_vrx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_pocket_pkg.sv
// Shared definitions for the Analogue Pocket video receiver.
package jtframe_pocket_pkg;
  localparam int CW_DEF     = 12;
  localparam int ERR_DESYNC = 0;
  localparam int ERR_SIZE   = 1;
  localparam int ERR_TMO    = 2;

  typedef enum logic {
    SEEK = 1'b0,
    LOCK = 1'b1
  } state_t;
endpackage

// File: rtl/jtframe_pocket_vrx_in.sv
// Input register stage: samples the Pocket bus once and flags non-skipped pixel events.
module jtframe_pocket_vrx_in (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pck_rgb,
  input  logic        pck_rgb_clk,
  input  logic        pck_de,
  input  logic        pck_skip,
  input  logic        pck_hs,
  input  logic        pck_vs,
  output logic        act,
  output logic [23:0] rgb,
  output logic        de,
  output logic        hs,
  output logic        vs
);
  logic clk1, clk2, skip1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb   <= '0;
      clk1  <= 1'b0;
      clk2  <= 1'b0;
      de    <= 1'b0;
      skip1 <= 1'b0;
      hs    <= 1'b0;
      vs    <= 1'b0;
    end else begin
      rgb   <= pck_rgb;
      clk1  <= pck_rgb_clk;
      clk2  <= clk1;
      de    <= pck_de;
      skip1 <= pck_skip;
      hs    <= pck_hs;
      vs    <= pck_vs;
    end
  end

  // rgb_clk rising edge seen in the first stage; skipped pixels never become events
  assign act = clk1 & ~clk2 & ~skip1;
endmodule

// File: rtl/jtframe_pocket_vrx.sv
// Pocket video bus receiver: rebuilds pixel strobe, level syncs, position and frame size.
// state | meaning
// SEEK  | waiting for a vs pulse, outputs held idle
// LOCK  | synchronised, counting lines/pixels and measuring frames
module jtframe_pocket_vrx
  import jtframe_pocket_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int HS_LEN  = 8,
  parameter int VS_LEN  = 3,
  parameter int TIMEOUT = 4000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [23:0]   pck_rgb,
  input  logic          pck_rgb_clk,
  input  logic          pck_de,
  input  logic          pck_skip,
  input  logic          pck_hs,
  input  logic          pck_vs,
  output logic          pxl_cen,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic [CW-1:0] width,
  output logic [CW-1:0] height,
  output logic          frame_done,
  output logic          locked,
  output logic [2:0]    err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        st;
  logic          act, in_de, in_hs, in_vs;
  logic [23:0]   in_rgb;
  logic [CW-1:0] hpos, vpos, last_w, hpos_inc, vpos_inc;
  logic          have_w, line_on, size_bad, tmo_hit;
  logic [7:0]    hs_cnt;
  logic [3:0]    vs_cnt;
  logic [TW-1:0] tmo;

  jtframe_pocket_vrx_in u_in (
    .clk         (clk),
    .rst_n       (rst_n),
    .pck_rgb     (pck_rgb),
    .pck_rgb_clk (pck_rgb_clk),
    .pck_de      (pck_de),
    .pck_skip    (pck_skip),
    .pck_hs      (pck_hs),
    .pck_vs      (pck_vs),
    .act         (act),
    .rgb         (in_rgb),
    .de          (in_de),
    .hs          (in_hs),
    .vs          (in_vs)
  );

  assign line_on  = hpos != '0;
  assign hpos_inc = &hpos ? hpos : hpos + 1'b1;
  assign vpos_inc = &vpos ? vpos : vpos + 1'b1;
  assign size_bad = line_on && have_w && (hpos != last_w);
  assign tmo_hit  = !in_hs && (tmo == TW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= SEEK;
      pxl_cen <= 1'b0;
      {red, green, blue} <= '0;
      de <= 1'b0;
      hs <= 1'b0;
      vs <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
      width <= '0;
      height <= '0;
      frame_done <= 1'b0;
      locked <= 1'b0;
      err <= '0;
      hpos <= '0;
      vpos <= '0;
      last_w <= '0;
      have_w <= 1'b0;
      hs_cnt <= '0;
      vs_cnt <= '0;
      tmo <= '0;
    end else begin
      pxl_cen    <= act;
      frame_done <= 1'b0;
      if (act) begin
        {red, green, blue} <= in_rgb;
        de <= 1'b0;
        if (st == SEEK) begin
          hcnt <= '0;
          vcnt <= '0;
          hs <= 1'b0;
          vs <= 1'b0;
          if (in_vs) begin
            st <= LOCK;
            locked <= 1'b1;
            hpos <= '0;
            vpos <= '0;
            have_w <= 1'b0;
            hs_cnt <= '0;
            vs_cnt <= '0;
            tmo <= TW'(TIMEOUT);
          end
        end else if (tmo_hit) begin
          st <= SEEK;
          locked <= 1'b0;
          err[ERR_TMO] <= 1'b1;
          hcnt <= '0;
          vcnt <= '0;
          hs <= 1'b0;
          vs <= 1'b0;
        end else begin
          tmo <= in_hs ? TW'(TIMEOUT) : tmo - 1'b1;
          if (in_de && (in_hs || in_vs)) err[ERR_DESYNC] <= 1'b1;
          // a sync closes the line in progress before anything else
          if ((in_hs || in_vs) && size_bad) err[ERR_SIZE] <= 1'b1;
          if ((in_hs || in_vs) && line_on) begin
            last_w <= hpos;
            have_w <= 1'b1;
          end
          if (in_hs) begin
            hs <= 1'b1;
            hs_cnt <= 8'(HS_LEN - 1);
          end else begin
            hs <= hs_cnt != '0;
            if (hs_cnt != '0) hs_cnt <= hs_cnt - 1'b1;
          end
          if (in_vs) begin
            vs <= 1'b1;
            vs_cnt <= 4'(VS_LEN);
          end else if (in_hs && vs_cnt != '0) begin
            vs_cnt <= vs_cnt - 1'b1;
            if (vs_cnt == 4'd1) vs <= 1'b0;
          end
          if (in_vs) begin
            width <= line_on ? hpos : last_w;
            height <= line_on ? vpos_inc : vpos;
            frame_done <= 1'b1;
            have_w <= 1'b0;
            hpos <= '0;
            vpos <= '0;
            hcnt <= '0;
            vcnt <= '0;
          end else if (in_hs) begin
            hpos <= '0;
            hcnt <= '0;
            if (line_on) begin
              vpos <= vpos_inc;
              vcnt <= vpos_inc;
            end else begin
              vcnt <= vpos;
            end
          end else begin
            hcnt <= hpos;
            vcnt <= vpos;
            if (in_de) begin
              de <= 1'b1;
              hpos <= hpos_inc;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_jtframe_pocket_vrx.sv
// Scoreboard bench for jtframe_pocket_vrx: randomized Pocket-style stream against a frame-level model.
module tb_jtframe_pocket_vrx;
  localparam int CW = 12, HS_LEN = 8, VS_LEN = 3, TIMEOUT = 4000;
  localparam int W = 32, H = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [23:0]   pck_rgb;
  logic          pck_rgb_clk, pck_de, pck_skip, pck_hs, pck_vs;
  logic          pxl_cen, de, hs, vs, frame_done, locked;
  logic [7:0]    red, green, blue;
  logic [CW-1:0] hcnt, vcnt, width, height;
  logic [2:0]    err;

  always #5 clk = ~clk;

  jtframe_pocket_vrx #(.CW(CW), .HS_LEN(HS_LEN), .VS_LEN(VS_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .pck_rgb(pck_rgb), .pck_rgb_clk(pck_rgb_clk), .pck_de(pck_de),
    .pck_skip(pck_skip), .pck_hs(pck_hs), .pck_vs(pck_vs), .pxl_cen(pxl_cen), .red(red),
    .green(green), .blue(blue), .de(de), .hs(hs), .vs(vs), .hcnt(hcnt), .vcnt(vcnt),
    .width(width), .height(height), .frame_done(frame_done), .locked(locked), .err(err)
  );

  typedef struct {
    int rgb;
    bit de, hs, vs, lock, fd;
    int hc, vc, w, h, err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, strobes = 0, pushes = 0, fd_seen = 0, fd_exp = 0;

  // reference model state, expressed per frame/line
  bit m_lock;
  int m_err, m_line, m_rows, m_prevw, m_lastw, m_w, m_h, m_hl, m_vl, m_idle;

  function automatic void chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic void model_reset();
    m_lock = 0; m_err = 0; m_line = 0; m_rows = 0; m_prevw = -1; m_lastw = 0;
    m_w = 0; m_h = 0; m_hl = 0; m_vl = 0; m_idle = 0;
  endfunction

  function automatic exp_t model_px(int rgb, bit pde, bit phs, bit pvs);
    exp_t e;
    e.rgb = rgb; e.de = 0; e.hs = 0; e.vs = 0; e.fd = 0; e.hc = 0; e.vc = 0;
    if (!m_lock) begin
      if (pvs) begin
        m_lock = 1; m_line = 0; m_rows = 0; m_prevw = -1; m_hl = 0; m_vl = 0; m_idle = 0;
      end
    end else begin
      m_idle = phs ? 0 : m_idle + 1;
      if (m_idle == TIMEOUT) begin
        m_lock = 0;
        m_err |= 4;
      end else begin
        if ((phs || pvs) && m_line > 0) begin
          if (m_prevw >= 0 && m_prevw != m_line) m_err |= 2;
          m_prevw = m_line; m_lastw = m_line; m_rows++; m_line = 0;
        end
        if (pde && (phs || pvs)) m_err |= 1;
        if (pvs) begin
          m_w = m_lastw; m_h = m_rows; m_rows = 0; m_prevw = -1;
          e.fd = 1; fd_exp++;
          m_vl = VS_LEN;
        end else if (phs && m_vl > 0) begin
          m_vl--;
        end
        if (phs) m_hl = HS_LEN;
        e.hs = m_hl > 0;
        if (m_hl > 0) m_hl--;
        e.vs = m_vl > 0;
        if (pde && !phs && !pvs) begin
          e.de = 1; e.hc = m_line; e.vc = m_rows; m_line++;
        end
      end
    end
    e.lock = m_lock; e.w = m_w; e.h = m_h; e.err = m_err;
    return e;
  endfunction

  task automatic send_px(bit pde, bit pskip, bit phs, bit pvs);
    int rgb;
    rgb = int'($urandom_range(0, 32'h00FF_FFFF));
    @(negedge clk);
    pck_rgb = rgb[23:0]; pck_de = pde; pck_skip = pskip; pck_hs = phs; pck_vs = pvs;
    pck_rgb_clk = 1'b1;
    if (!pskip) begin
      sb.push_back(model_px(rgb, pde, phs, pvs));
      pushes++;
    end
    @(negedge clk);
    pck_rgb_clk = 1'b0; pck_hs = 1'b0; pck_vs = 1'b0;
    pck_de = 1'($urandom); pck_skip = 1'($urandom); pck_rgb = 24'($urandom);
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic send_line(int nde, bit vs_hs, bit vs_sep, bit skip4, bit de_hs);
    send_px(de_hs, 0, 1, vs_hs);
    send_px(0, 0, 0, vs_sep);
    send_px(0, 0, 0, 0);
    for (int i = 0; i < nde; i++) begin
      if (skip4 && i > 0 && (i % 3) == 0) send_px(1, 1, 1'($urandom), 0);
      send_px(1, 0, 0, 0);
    end
    send_px(0, 0, 0, 0);
    send_px(0, 0, 0, 0);
  endtask

  task automatic send_frame(int bad_line, int err_line, bit skip4, bit vs_sep);
    int nde;
    for (int l = 0; l < H + 2; l++) begin
      nde = (l >= H) ? 0 : (l == bad_line) ? W - 1 : W;
      send_line(nde, l == 0 && !vs_sep, l == 0 && vs_sep, skip4, l == err_line);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rgb"}, int'({red, green, blue}), 0);
    chk({tag, "_flags"}, int'({pxl_cen, de, hs, vs, frame_done, locked, err}), 0);
    chk({tag, "_hcnt"}, int'(hcnt), 0);
    chk({tag, "_vcnt"}, int'(vcnt), 0);
    chk({tag, "_width"}, int'(width), 0);
    chk({tag, "_height"}, int'(height), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_seen++;
      if (pxl_cen) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_strobe got pxl_cen=1 expected no strobe at %0t", $time);
        end else begin
          mon_e = sb.pop_front();
          strobes++;
          chk("rgb", int'({red, green, blue}), mon_e.rgb);
          chk("de", int'(de), int'(mon_e.de));
          chk("hs", int'(hs), int'(mon_e.hs));
          chk("vs", int'(vs), int'(mon_e.vs));
          chk("locked", int'(locked), int'(mon_e.lock));
          chk("frame_done", int'(frame_done), int'(mon_e.fd));
          chk("width", int'(width), mon_e.w);
          chk("height", int'(height), mon_e.h);
          chk("err", int'(err), mon_e.err);
          if (mon_e.de) begin
            chk("hcnt", int'(hcnt), mon_e.hc);
            chk("vcnt", int'(vcnt), mon_e.vc);
          end
        end
      end else begin
        chk("frame_done_without_cen", int'(frame_done), 0);
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog expired got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pck_rgb = '0; pck_rgb_clk = 1'b0; pck_de = 1'b0; pck_skip = 1'b0; pck_hs = 1'b0; pck_vs = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // unlocked traffic, then normal frames, skips, size error, desync, separate vs
    send_line(W, 0, 0, 0, 0);
    send_line(W, 0, 0, 0, 0);
    send_frame(-1, -1, 0, 0);
    send_frame(-1, -1, 0, 0);
    send_frame(-1, -1, 1, 0);
    send_frame(10, -1, 0, 0);
    send_frame(-1, 5, 0, 0);
    send_frame(-1, -1, 0, 1);
    send_frame(-1, -1, 0, 0);

    // no hs for TIMEOUT pixels drops lock
    for (int i = 0; i < TIMEOUT + 5; i++) send_px(1'($urandom), 0, 0, 0);
    drain();
    chk("locked_after_timeout", int'(locked), 0);
    chk("err_after_timeout", int'(err), 7);

    send_frame(-1, -1, 0, 0);
    send_frame(-1, -1, 0, 0);

    // asynchronous reset in the middle of a line
    send_px(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) send_px(1, 0, 0, 0);
    drain();
    chk("locked_before_reset", int'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midline_reset");
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send_line(W, 0, 0, 0, 0);
    send_line(W, 0, 0, 0, 0);
    send_frame(-1, -1, 0, 0);
    send_frame(-1, -1, 0, 0);
    send_frame(-1, -1, 0, 0);
    drain();
    repeat (4) @(negedge clk);

    chk("final_width", int'(width), W);
    chk("final_height", int'(height), H);
    chk("final_err", int'(err), 0);
    chk("frame_done_count", fd_seen, fd_exp);
    chk("strobe_count", strobes, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
